rr_arb4_ctrl: RTL and testbench
===============================

# rr_arb4_ctrl

Four-requester round-robin arbiter controller sharing one downstream resource, such as a bus or functional unit. It runs a one-hot five-state machine: IDLE plus one GRANT state per requester. The state is held in the team's 5-bit one-hot state register (`state5_reg`), whose asynchronous reset value is 5'b00001, meaning IDLE. A hold-time counter bounds how long any one requester may own the resource.

## Interface
Parameters:
- HOLD_MAX, default 15: maximum consecutive grant cycles per ownership. Legal range 1–15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low system reset.
- req  input  [3:0]  request per requester; level-sensitive, held until served.
- done  input  1  current owner releases the resource; sampled only in a GRANT state.
- gnt  output  [3:0]  one-hot grant, or 4'b0000 in IDLE; decoded from state only (Moore).
- busy  output  1  high in any GRANT state.
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.
- state  output  [4:0]  current one-hot state, for debug. Bit 0 is IDLE; bit k+1 is GRANTk.

## Operation
- States: IDLE = 5'b00001, GRANT0 = 5'b00010, GRANT1 = 5'b00100, GRANT2 = 5'b01000, GRANT3 = 5'b10000. Exactly one bit is ever set.
- Outputs: gnt = state[4:1] and busy = |state[4:1]. Both are pure functions of state.
- Round-robin pointer: a 2-bit register `last` holds the index of the most recent grant.
  - Reset value is 2'd3, so requester 0 has highest priority after reset.
  - `last` updates on entry to GRANTk.
- IDLE behaviour:
  - No req bit set: remain in IDLE.
  - Otherwise go to GRANTk, where k is the first index with req[k]=1 searching last+1, last+2, last+3, last (mod 4).
- GRANTk exits to IDLE, on the next edge, when any of the following holds:
  - done=1;
  - req[k]=0 (requester withdrew);
  - the hold counter has reached HOLD_MAX.
- Otherwise GRANTk holds.
- There is no direct GRANT-to-GRANT transition. Every release passes through exactly one IDLE cycle, which serves as bus turnaround.
- Hold counter:
  - 4-bit unsigned, cleared to 0 in IDLE.
  - Increments each cycle in a GRANT state and saturates at HOLD_MAX.
  - It reads n during the n-th grant cycle, counting from 1.
  - When it equals HOLD_MAX, the grant is released and timeout is registered high for the following cycle (the IDLE cycle). This happens only if neither done nor a req drop caused the release in the same cycle.
- Simultaneous events:
  - done and hold limit in the same cycle: treated as a normal release, with no timeout pulse.
  - done while in IDLE: ignored.
- Reset mid-grant: all outputs clear immediately (asynchronously) to their reset values, and the counter and `last` return to their reset values.
- Reset values: state=5'b00001, gnt=4'b0000, busy=0, timeout=0, counter=0, last=2'd3.

## Timing
- Request-to-grant latency: req sampled high in IDLE at edge t gives gnt visible after edge t, so it is seen in cycle t+1.
- Release latency: done high in cycle c gives gnt low in cycle c+1. The next grant can appear no earlier than cycle c+2.
- Maximum ownership is HOLD_MAX cycles. The worst-case wait for a persistent requester is 3×(HOLD_MAX+1) cycles.
- No combinational path from any input to any output.

## Structure
- Package `arb_pkg` holds:
  - localparams for the five one-hot state encodings;
  - NUM_REQ = 4;
  - the 4-bit counter width.
- Sub-module: `state5_reg` holds state. Next-state logic is combinational in this block and feeds nxt_state.
- The round-robin priority search is a natural small function in `arb_pkg`, named `rr_pick(last, req)`, returning the index and a valid flag.

## Test plan
- Reset: assert rst_n=0 mid-GRANT2 → state=5'b00001, gnt=0, busy=0, timeout=0 immediately. First request after release of reset is req=4'b1111, which gives GRANT0.
- Rotation: hold req=4'b1111 and pulse done one cycle after each grant → grant order 0,1,2,3,0, each grant separated by one IDLE cycle.
- Skip idle requesters: last=0 with req=4'b1001 → GRANT3, then GRANT0. Requesters 1 and 2 are never granted.
- Timeout with HOLD_MAX=15: req[1] held and done never asserted → gnt=4'b0010 for exactly 15 cycles, then IDLE with timeout=1 for one cycle. With req still held, GRANT1 is re-granted after that IDLE cycle.
- Simultaneous events: done=1 on the 15th grant cycle → release with timeout=0. Separately, req[k] dropped mid-grant → IDLE on the next edge.
- One-hot invariant: random req/done for 10k cycles → state always has exactly one bit set, and gnt is always zero or one-hot.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types, encodings and helpers for the four-requester round-robin arbiter.
package arb_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned ST_W    = 5;

   localparam logic [ST_W-1:0] ST_IDLE = 5'b00001;
   localparam logic [ST_W-1:0] ST_GNT0 = 5'b00010;
   localparam logic [ST_W-1:0] ST_GNT1 = 5'b00100;
   localparam logic [ST_W-1:0] ST_GNT2 = 5'b01000;
   localparam logic [ST_W-1:0] ST_GNT3 = 5'b10000;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   // First requester after `last`, wrapping round so `last` itself is tried last.
   function automatic rr_pick_t rr_pick(input logic [IDX_W-1:0] last,
                                        input logic [NUM_REQ-1:0] req);
      rr_pick_t         pick;
      logic [IDX_W-1:0] k;
      pick = '0;
      for (int i = 1; i <= int'(NUM_REQ); i++) begin
         k = IDX_W'(last + IDX_W'(i));
         if (!pick.valid && req[k]) begin
            pick.valid = 1'b1;
            pick.idx   = k;
         end
      end
      return pick;
   endfunction

   function automatic logic [ST_W-1:0] grant_state(input logic [IDX_W-1:0] idx);
      return ST_W'(ST_GNT0 << idx);
   endfunction

endpackage

// File: rtl/state5_reg.sv
// One-hot five-state register; resets to IDLE.
module state5_reg
   import arb_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ST_W-1:0] nxt_state,
   output logic [ST_W-1:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nxt_state;
   end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Round-robin arbiter for four requesters with a bounded hold time and
// one mandatory IDLE turnaround cycle between owners.
module rr_arb4_ctrl
   import arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 15
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] gnt,
   output logic               busy,
   output logic               timeout,
   output logic [ST_W-1:0]    state
);

   logic [ST_W-1:0]  nxt_state;
   logic [IDX_W-1:0] last, nxt_last;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic             nxt_timeout;
   logic             own_req;
   logic             hold_hit;
   rr_pick_t         pick;

   state5_reg u_state (
      .clk       (clk),
      .rst_n     (rst_n),
      .nxt_state (nxt_state),
      .state     (state)
   );

   // Moore outputs taken straight from the state register.
   assign gnt  = state[ST_W-1:1];
   assign busy = |state[ST_W-1:1];

   // `last` always names the current owner while in a GRANT state.
   always_comb begin
      nxt_state   = state;
      nxt_last    = last;
      nxt_cnt     = cnt;
      nxt_timeout = 1'b0;
      pick        = rr_pick(last, req);
      own_req     = req[last];
      hold_hit    = (cnt == CNT_W'(HOLD_MAX));
      case (state)
         ST_IDLE: begin
            nxt_cnt = '0;
            if (pick.valid) begin
               nxt_state = grant_state(pick.idx);
               nxt_last  = pick.idx;
               nxt_cnt   = CNT_W'(1);
            end
         end
         ST_GNT0, ST_GNT1, ST_GNT2, ST_GNT3: begin
            if (done || !own_req || hold_hit) begin
               nxt_state   = ST_IDLE;
               nxt_cnt     = '0;
               nxt_timeout = hold_hit && !done && own_req;
            end else if (cnt != CNT_W'(HOLD_MAX)) begin
               nxt_cnt = cnt + CNT_W'(1);
            end
         end
         default: begin
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last    <= IDX_W'(3);
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         last    <= nxt_last;
         cnt     <= nxt_cnt;
         timeout <= nxt_timeout;
      end
   end

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Bench for rr_arb4_ctrl: directed scenarios plus random traffic against an
// ownership-level reference model.
module tb_rr_arb4_ctrl;

   localparam int HOLD = 15;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic       busy;
   logic       timeout;
   logic [4:0] state;

   int n_chk;
   int n_pass;

   // Reference model: who owns the resource, for how long, and who went last.
   int m_owner;
   int m_held;
   int m_last;
   bit m_to;

   rr_arb4_ctrl #(.HOLD_MAX(HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .busy    (busy),
      .timeout (timeout),
      .state   (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 3;
      m_to    = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r, input logic d);
      m_to = 1'b0;
      if (m_owner < 0) begin
         for (int i = 1; i <= 4; i++) begin
            int k;
            k = (m_last + i) % 4;
            if (m_owner < 0 && r[k]) begin
               m_owner = k;
               m_last  = k;
               m_held  = 1;
            end
         end
      end else if (d || !r[m_owner] || m_held == HOLD) begin
         m_to    = (m_held == HOLD) && !d && r[m_owner];
         m_owner = -1;
         m_held  = 0;
      end else begin
         m_held++;
      end
   endtask

   task automatic check_outputs();
      int exp_gnt;
      exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
      chk("gnt",     32'(gnt),     32'(exp_gnt));
      chk("state",   32'(state),   (m_owner < 0) ? 32'd1 : 32'(exp_gnt << 1));
      chk("busy",    32'(busy),    32'(m_owner >= 0));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("onehot",  32'($countones(state)), 32'd1);
      chk("gnt_ok",  32'((gnt == 4'b0000) || $onehot(gnt)), 32'd1);
   endtask

   task automatic cycle(input logic [3:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      model_step(r, d);
      #1;
      check_outputs();
   endtask

   initial begin
      int n;
      int rot_exp [5];
      logic [3:0] r;
      logic       d;
      logic [3:0] seen;
      n_chk  = 0;
      n_pass = 0;
      rot_exp = '{0, 1, 2, 3, 0};
      model_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;
      #12;
      chk("rst_state",   32'(state),   32'd1);
      chk("rst_gnt",     32'(gnt),     32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      rst_n = 1'b1;

      // Rotation with everyone requesting and done one cycle into each grant.
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1111, 1'b0);
         chk("rotation", 32'(gnt), 32'(1 << rot_exp[i]));
         cycle(4'b1111, 1'b1);
         chk("rot_turnaround", 32'(state), 32'd1);
      end

      // Skip idle requesters: last=0, only 3 and 0 asking.
      seen = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         cycle(4'b1001, 1'b0);
         seen |= gnt;
         chk("skip", 32'(gnt), (i == 0) ? 32'h8 : 32'h1);
         cycle(4'b1001, 1'b1);
      end
      chk("skip_none12", 32'(seen & 4'b0110), 32'd0);

      // Asynchronous reset in the middle of GRANT2.
      cycle(4'b0100, 1'b0);
      chk("pre_rst_g2", 32'(state), 32'h08);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_state",   32'(state),   32'd1);
      chk("midrst_gnt",     32'(gnt),     32'd0);
      chk("midrst_busy",    32'(busy),    32'd0);
      chk("midrst_timeout", 32'(timeout), 32'd0);
      #2 rst_n = 1'b1;
      cycle(4'b1111, 1'b0);
      chk("post_rst_g0", 32'(state), 32'h02);
      cycle(4'b0000, 1'b1);

      // Hold limit on a persistent requester 1.
      cycle(4'b0010, 1'b0);
      n = (gnt == 4'b0010) ? 1 : 0;
      for (int i = 0; i < 40 && gnt == 4'b0010; i++) begin
         cycle(4'b0010, 1'b0);
         if (gnt == 4'b0010) n++;
      end
      chk("hold_len",   32'(n),       32'(HOLD));
      chk("to_pulse",   32'(timeout), 32'd1);
      cycle(4'b0010, 1'b0);
      chk("regrant",    32'(gnt),     32'h2);
      chk("to_cleared", 32'(timeout), 32'd0);

      // done on the last allowed cycle: plain release, no timeout.
      for (int i = 0; i < HOLD - 1; i++) cycle(4'b0010, 1'b0);
      cycle(4'b0010, 1'b1);
      chk("done_at_limit_gnt", 32'(gnt),     32'd0);
      chk("done_at_limit_to",  32'(timeout), 32'd0);

      // Requester withdraws mid-grant.
      cycle(4'b0010, 1'b0);
      cycle(4'b0010, 1'b0);
      cycle(4'b0000, 1'b0);
      chk("drop_gnt", 32'(gnt),     32'd0);
      chk("drop_to",  32'(timeout), 32'd0);

      // Random traffic: sticky requests, occasional done.
      r = 4'b0000;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 5) == 0) r = 4'($urandom);
         d = ($urandom_range(0, 7) == 0);
         cycle(r, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
